// File: rtl/writeback_stage.sv
// Purpose : MIPS write-back stage; MEM/WB register, load formatting, regfile write port, retire count.
// Latency : 1 cycle, every output registered, no combinational input-to-output path.
// Backpres: wb_i_stall freezes all state (upstream holds inputs); wb_i_flush loads a bubble.
//
// Ports:
//   wb_clk / wb_rst          clock, synchronous active-high reset
//   wb_i_ce, wb_i_stall, wb_i_flush   entry valid and pipeline control
//   wb_i_reg_wr, wb_i_reg_dst, wb_i_mem_to_reg, wb_i_load_type, wb_i_byte_off,
//   wb_i_addr_rd, wb_i_alu_result, wb_i_mem_data      memory-stage result
//   wb_o_ce, wb_o_reg_wr, wb_o_reg_dst, wb_o_addr_rd, wb_o_data_rd   regfile write port
//   wb_o_exc                 misaligned-load flag for the current entry
//   wb_o_retired             32-bit wrapping retired-instruction count
module writeback_stage #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic              wb_i_ce,
    input  logic              wb_i_stall,
    input  logic              wb_i_flush,
    input  logic              wb_i_reg_wr,
    input  logic              wb_i_reg_dst,
    input  logic              wb_i_mem_to_reg,
    input  logic [2:0]        wb_i_load_type,
    input  logic [1:0]        wb_i_byte_off,
    input  logic [AWIDTH-1:0] wb_i_addr_rd,
    input  logic [DWIDTH-1:0] wb_i_alu_result,
    input  logic [DWIDTH-1:0] wb_i_mem_data,
    output logic              wb_o_ce,
    output logic              wb_o_reg_wr,
    output logic              wb_o_reg_dst,
    output logic [AWIDTH-1:0] wb_o_addr_rd,
    output logic [DWIDTH-1:0] wb_o_data_rd,
    output logic              wb_o_exc,
    output logic [31:0]       wb_o_retired
);

    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;

    // Registered state
    logic              ce_q,      ce_d;
    logic              reg_wr_q,  reg_wr_d;
    logic              reg_dst_q, reg_dst_d;
    logic [AWIDTH-1:0] addr_rd_q, addr_rd_d;
    logic [DWIDTH-1:0] data_rd_q, data_rd_d;
    logic              exc_q,     exc_d;
    logic [31:0]       retired_q, retired_d;

    // Combinational view of the incoming entry
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;
    logic [DWIDTH-1:0] load_fmt;
    logic              is_half;
    logic              is_byte;
    logic              exc_in;
    logic              wr_in;
    logic              retire_in;

    // Lane extraction; little-endian, byte 0 in bits [7:0].
    always_comb begin
        half_sel = wb_i_byte_off[1] ? wb_i_mem_data[31:16] : wb_i_mem_data[15:0];
        byte_sel = wb_i_mem_data[7:0];
        case (wb_i_byte_off)
            2'd1:    byte_sel = wb_i_mem_data[15:8];
            2'd2:    byte_sel = wb_i_mem_data[23:16];
            2'd3:    byte_sel = wb_i_mem_data[31:24];
            default: byte_sel = wb_i_mem_data[7:0];
        endcase
    end

    // Unused load-type codes 5..7 fall through to the full-word default.
    always_comb begin
        load_fmt = wb_i_mem_data;
        case (wb_i_load_type)
            LT_LH:   load_fmt = {{(DWIDTH-16){half_sel[15]}}, half_sel};
            LT_LHU:  load_fmt = {{(DWIDTH-16){1'b0}}, half_sel};
            LT_LB:   load_fmt = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
            LT_LBU:  load_fmt = {{(DWIDTH-8){1'b0}}, byte_sel};
            default: load_fmt = wb_i_mem_data;
        endcase
    end

    always_comb begin
        is_half   = (wb_i_load_type == LT_LH) || (wb_i_load_type == LT_LHU);
        is_byte   = (wb_i_load_type == LT_LB) || (wb_i_load_type == LT_LBU);
        // Byte loads can never be misaligned; everything else not half/byte is a word.
        exc_in    = wb_i_ce & wb_i_mem_to_reg &
                    ((!is_half & !is_byte & (wb_i_byte_off != 2'd0)) |
                     (is_half & wb_i_byte_off[0]));
        // $0 is hardwired to zero, so its writes are dropped here.
        wr_in     = wb_i_ce & wb_i_reg_wr & !exc_in & (wb_i_addr_rd != '0);
        retire_in = wb_i_ce & !exc_in;
    end

    // Next state: flush beats stall, stall beats capture.
    always_comb begin
        ce_d      = ce_q;
        reg_wr_d  = reg_wr_q;
        reg_dst_d = reg_dst_q;
        addr_rd_d = addr_rd_q;
        data_rd_d = data_rd_q;
        exc_d     = exc_q;
        retired_d = retired_q;
        if (wb_i_flush) begin
            ce_d      = 1'b0;
            reg_wr_d  = 1'b0;
            reg_dst_d = 1'b0;
            addr_rd_d = '0;
            data_rd_d = '0;
            exc_d     = 1'b0;
        end else if (!wb_i_stall) begin
            ce_d      = wb_i_ce;
            reg_wr_d  = wr_in;
            reg_dst_d = wb_i_reg_dst;
            addr_rd_d = wb_i_addr_rd;
            data_rd_d = wb_i_mem_to_reg ? load_fmt : wb_i_alu_result;
            exc_d     = exc_in;
            if (retire_in) begin
                retired_d = retired_q + 32'd1;
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            ce_q      <= 1'b0;
            reg_wr_q  <= 1'b0;
            reg_dst_q <= 1'b0;
            addr_rd_q <= '0;
            data_rd_q <= '0;
            exc_q     <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            ce_q      <= ce_d;
            reg_wr_q  <= reg_wr_d;
            reg_dst_q <= reg_dst_d;
            addr_rd_q <= addr_rd_d;
            data_rd_q <= data_rd_d;
            exc_q     <= exc_d;
            retired_q <= retired_d;
        end
    end

    assign wb_o_ce      = ce_q;
    assign wb_o_reg_wr  = reg_wr_q;
    assign wb_o_reg_dst = reg_dst_q;
    assign wb_o_addr_rd = addr_rd_q;
    assign wb_o_data_rd = data_rd_q;
    assign wb_o_exc     = exc_q;
    assign wb_o_retired = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, hand-written stall/flush/reset/wrap
// sequences, then randomized traffic checked against a spec-level reference model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst, ce, stall, flush, reg_wr, reg_dst, m2r;
    logic [2:0]  lt;
    logic [1:0]  off;
    logic [4:0]  addr;
    logic [31:0] alu, mem;
    logic        o_ce, o_wr, o_dst, o_exc;
    logic [4:0]  o_addr;
    logic [31:0] o_data, o_ret;

    int checks = 0;
    int failures = 0;

    writeback_stage #(.AWIDTH(5), .DWIDTH(32)) dut (
        .wb_clk(clk), .wb_rst(rst), .wb_i_ce(ce), .wb_i_stall(stall), .wb_i_flush(flush),
        .wb_i_reg_wr(reg_wr), .wb_i_reg_dst(reg_dst), .wb_i_mem_to_reg(m2r),
        .wb_i_load_type(lt), .wb_i_byte_off(off), .wb_i_addr_rd(addr),
        .wb_i_alu_result(alu), .wb_i_mem_data(mem),
        .wb_o_ce(o_ce), .wb_o_reg_wr(o_wr), .wb_o_reg_dst(o_dst), .wb_o_addr_rd(o_addr),
        .wb_o_data_rd(o_data), .wb_o_exc(o_exc), .wb_o_retired(o_ret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_ce, input logic e_wr, input logic e_dst,
                           input logic [4:0] e_addr, input logic [31:0] e_data,
                           input logic e_exc, input logic [31:0] e_ret);
        chk({tag, ".ce"},   {31'd0, o_ce},  {31'd0, e_ce});
        chk({tag, ".wr"},   {31'd0, o_wr},  {31'd0, e_wr});
        chk({tag, ".dst"},  {31'd0, o_dst}, {31'd0, e_dst});
        chk({tag, ".addr"}, {27'd0, o_addr}, {27'd0, e_addr});
        chk({tag, ".data"}, o_data, e_data);
        chk({tag, ".exc"},  {31'd0, o_exc}, {31'd0, e_exc});
        chk({tag, ".ret"},  o_ret, e_ret);
    endtask

    // ---------------- reference model (spec-level arithmetic) ----------------
    function automatic logic [31:0] ref_load(input int t, input int o, input logic [31:0] w);
        logic [31:0] v;
        if (t == 1 || t == 2) begin
            v = (w >> (16 * (o / 2))) & 32'h0000_FFFF;
            if (t == 1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else if (t == 3 || t == 4) begin
            v = (w >> (8 * o)) & 32'h0000_00FF;
            if (t == 3 && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else begin
            v = w;
        end
        return v;
    endfunction

    logic        m_ce, m_wr, m_dst, m_exc;
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_ret;

    task automatic model_step();
        int  t, o;
        bit  mis;
        t = int'(lt);
        o = int'(off);
        if (rst) begin
            {m_ce, m_wr, m_dst, m_exc} = 4'b0;
            m_addr = 0; m_data = 0; m_ret = 0;
        end else if (flush) begin
            {m_ce, m_wr, m_dst, m_exc} = 4'b0;
            m_addr = 0; m_data = 0;
        end else if (!stall) begin
            if (t == 1 || t == 2)      mis = (o % 2) == 1;
            else if (t == 3 || t == 4) mis = 0;
            else                       mis = (o != 0);
            m_exc  = ce && m2r && mis;
            m_ce   = ce;
            m_wr   = ce && reg_wr && !m_exc && (addr != 0);
            m_dst  = reg_dst;
            m_addr = addr;
            m_data = m2r ? ref_load(t, o, mem) : alu;
            if (ce && !m_exc) m_ret = m_ret + 1;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ce, wr, dst, m2r;
        logic [2:0]  lt;
        logic [1:0]  off;
        logic [4:0]  addr;
        logic [31:0] alu;
        logic        e_ce, e_wr, e_exc;
        logic [31:0] e_data, e_ret;
    } vec_t;

    vec_t vt[12];

    initial begin
        // ce  wr  dst m2r lt off addr alu            e_ce e_wr e_exc e_data         e_ret
        vt[0]  = '{1, 1, 1, 0, 0, 0,  8, 32'h0000_1234, 1, 1, 0, 32'h0000_1234, 1};
        vt[1]  = '{1, 1, 0, 1, 3, 3,  9, 32'h0,         1, 1, 0, 32'hFFFF_FF80, 2};
        vt[2]  = '{1, 1, 0, 1, 4, 2,  9, 32'h0,         1, 1, 0, 32'h0000_00FF, 3};
        vt[3]  = '{1, 1, 1, 1, 1, 2, 10, 32'h0,         1, 1, 0, 32'hFFFF_80FF, 4};
        vt[4]  = '{1, 1, 1, 1, 2, 0, 11, 32'h0,         1, 1, 0, 32'h0000_7F01, 5};
        vt[5]  = '{1, 1, 0, 1, 0, 2,  5, 32'h0,         1, 0, 1, 32'h80FF_7F01, 5};
        vt[6]  = '{1, 1, 0, 1, 0, 0,  5, 32'h0,         1, 1, 0, 32'h80FF_7F01, 6};
        vt[7]  = '{1, 1, 1, 0, 0, 0,  0, 32'hDEAD_BEEF, 1, 0, 0, 32'hDEAD_BEEF, 7};
        vt[8]  = '{1, 1, 0, 1, 1, 1, 12, 32'h0,         1, 0, 1, 32'h0000_7F01, 7};
        vt[9]  = '{0, 1, 1, 1, 4, 1,  3, 32'h0,         0, 0, 0, 32'h0000_007F, 7};
        vt[10] = '{1, 1, 0, 1, 6, 0, 31, 32'h0,         1, 1, 0, 32'h80FF_7F01, 8};
        vt[11] = '{1, 1, 1, 0, 0, 2,  4, 32'h0000_0055, 1, 1, 0, 32'h0000_0055, 9};

        rst = 1; ce = 0; stall = 0; flush = 0; reg_wr = 0; reg_dst = 0; m2r = 0;
        lt = 0; off = 0; addr = 0; alu = 0; mem = 32'h80FF_7F01;
        tick(); tick();
        chk_all("reset", 0, 0, 0, 5'd0, 32'h0, 0, 32'd0);
        rst = 0;

        for (int i = 0; i < 12; i++) begin
            ce = vt[i].ce; reg_wr = vt[i].wr; reg_dst = vt[i].dst; m2r = vt[i].m2r;
            lt = vt[i].lt; off = vt[i].off; addr = vt[i].addr; alu = vt[i].alu;
            tick();
            chk_all($sformatf("vec%0d", i), vt[i].e_ce, vt[i].e_wr, vt[i].dst,
                    vt[i].addr, vt[i].e_data, vt[i].e_exc, vt[i].e_ret);
        end

        // ---- stall holds entry A through changing inputs ----
        ce = 1; reg_wr = 1; reg_dst = 1; m2r = 0; lt = 0; off = 0; addr = 10; alu = 32'hAAAA_0001;
        tick();
        chk_all("stallA", 1, 1, 1, 5'd10, 32'hAAAA_0001, 0, 32'd10);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            addr = 5'(20 + k); alu = 32'h5555_0000 + k; reg_dst = 0; m2r = k[0]; lt = 3'(k);
            tick();
            chk_all($sformatf("stall%0d", k), 1, 1, 1, 5'd10, 32'hAAAA_0001, 0, 32'd10);
        end
        flush = 1;
        tick();
        chk_all("stall_flush", 0, 0, 0, 5'd0, 32'h0, 0, 32'd10);
        stall = 0;
        ce = 1; reg_wr = 1; addr = 7; alu = 32'h1;
        tick();
        chk_all("flush_only", 0, 0, 0, 5'd0, 32'h0, 0, 32'd10);
        flush = 0;
        tick();
        chk_all("after_flush", 1, 1, 0, 5'd7, 32'h1, 0, 32'd11);

        // ---- counter wrap ----
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        ce = 1; reg_wr = 1; m2r = 0; addr = 2; alu = 32'h0000_0ABC;
        tick();
        chk_all("wrap", 1, 1, 0, 5'd2, 32'h0000_0ABC, 0, 32'd0);
        tick();
        chk("wrap_next", o_ret, 32'd1);

        // ---- reset during stall ----
        stall = 1; rst = 1;
        tick();
        chk_all("rst_in_stall", 0, 0, 0, 5'd0, 32'h0, 0, 32'd0);
        rst = 0; stall = 0; ce = 1; reg_wr = 1; addr = 6; alu = 32'h66;
        tick();
        chk_all("first_after_rst", 1, 1, 0, 5'd6, 32'h66, 0, 32'd1);

        // ---- randomized traffic vs model ----
        rst = 1; stall = 0; flush = 0;
        model_step();
        tick();
        rst = 0;
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 39) == 0);
            stall   = ($urandom_range(0, 4) == 0);
            flush   = ($urandom_range(0, 7) == 0);
            ce      = ($urandom_range(0, 3) != 0);
            reg_wr  = 1'($urandom);
            reg_dst = 1'($urandom);
            m2r     = 1'($urandom);
            lt      = 3'($urandom_range(0, 7));
            off     = 2'($urandom);
            addr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            alu     = $urandom;
            mem     = $urandom;
            model_step();
            tick();
            chk_all($sformatf("rand%0d", n), m_ce, m_wr, m_dst, m_addr, m_data, m_exc, m_ret);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the five-stage MIPS pipeline. It registers the memory-stage result (MEM/WB pipeline register), formats sub-word loads, selects ALU versus memory data, and drives the register-file write port of the decoder stage: write enable, destination select, write address and write data. It also flags misaligned loads and counts retired instructions.

## Interface
- AWIDTH, 5, register address width
- DWIDTH, 32, data width (load formatting is defined for 32 only)
- wb_clk  in  1  clock, all state updates on rising edge
- wb_rst  in  1  synchronous reset, active-high
- wb_i_ce  in  1  memory-stage instruction valid
- wb_i_stall  in  1  freeze the stage
- wb_i_flush  in  1  replace next captured entry with a bubble
- wb_i_reg_wr  in  1  instruction writes a register
- wb_i_reg_dst  in  1  destination select (1 = rd, 0 = rt), passed through
- wb_i_mem_to_reg  in  1  1 = write formatted load data, 0 = ALU result
- wb_i_load_type  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5–7 treated as LW
- wb_i_byte_off  in  2  effective address bits [1:0]
- wb_i_addr_rd  in  AWIDTH  resolved destination register
- wb_i_alu_result  in  DWIDTH  ALU result
- wb_i_mem_data  in  DWIDTH  aligned word read from data memory
- wb_o_ce  out  1  registered valid
- wb_o_reg_wr  out  1  register-file write enable
- wb_o_reg_dst  out  1  registered destination select
- wb_o_addr_rd  out  AWIDTH  write address
- wb_o_data_rd  out  DWIDTH  write data
- wb_o_exc  out  1  misaligned-load exception for the current entry
- wb_o_retired  out  32  retired-instruction count

## Operation
- Priority on each edge: reset > flush > stall > capture.
- Reset: every output is 0, including wb_o_retired.
- Flush (not stalled or stalled): the output register loads a bubble. wb_o_ce, wb_o_reg_wr and wb_o_exc are 0; the other fields are 0. The counter is unchanged.
- Stall without flush: all output registers and the counter hold. Repeating a write is harmless. Upstream must hold its inputs.
- Capture (no stall, no flush): wb_o_ce <= wb_i_ce. The remaining fields load from the inputs as formatted below.
- Load formatting (little-endian lanes, off = wb_i_byte_off):
  - LW: the full word.
  - LH / LHU: halfword mem_data[16*off[1]+15 : 16*off[1]], sign- or zero-extended.
  - LB / LBU: byte mem_data[8*off+7 : 8*off], sign- or zero-extended.
- Data select: wb_o_data_rd = formatted load if wb_i_mem_to_reg, else wb_i_alu_result.
- Misalignment: exc = ce & mem_to_reg & ((LW & off != 0) | ((LH | LHU) & off[0])).
- Write enable: wb_o_reg_wr = ce & reg_wr & !exc & (addr_rd != 0). Writes to $0 are suppressed.
- wb_o_exc is registered with the entry and is not sticky.
- Retire counter increments by 1 on every capture with wb_i_ce = 1 and exc = 0. It wraps from 0xFFFFFFFF to 0.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N and are valid through edge N+1.
- All outputs are registered; there is no combinational input-to-output path.
- The register file consumes wb_o_* during the cycle they are valid. A decoder-stage read of the same register in that cycle sees the old value; forwarding is outside this block.
- The counter reflects a retire in the same cycle as the retiring entry's outputs.
- Reset asserted mid-stall or mid-flush clears everything on that edge. The first capture is possible on the edge after reset deasserts.

## Test plan
- Reset, then ALU write: ce=1, reg_wr=1, mem_to_reg=0, addr_rd=8, alu=0x0000_1234.
  - Next cycle: reg_wr=1, addr_rd=8, data_rd=0x0000_1234.
  - retired=1.
- Byte and half loads: mem_data=0x80FF_7F01.
  - LB off=3 -> 0xFFFF_FF80.
  - LBU off=2 -> 0x0000_00FF.
  - LH off=2 -> 0xFFFF_80FF.
  - LHU off=0 -> 0x0000_7F01.
- Misaligned: LW off=2, reg_wr=1, addr 5.
  - Next cycle: exc=1, reg_wr=0, counter unchanged.
  - Following valid LW off=0 -> exc=0.
- $0 write: reg_wr=1, addr_rd=0, alu=0xDEAD_BEEF.
  - Next cycle: reg_wr=0, ce=1, counter +1.
- Stall then flush:
  - Capture A, stall 3 cycles with changing inputs: outputs stay A, counter +1 only.
  - Assert flush with stall: next edge ce=0, reg_wr=0.
- Counter wrap: preload by running 2^32−1 retires (or force internal value 0xFFFF_FFFF), one more retire -> 0. Reset asserted during stall -> all outputs 0 next edge.
